// File: rtl/combo_lock_ctrl.sv
// Session controller for the combination checker: synchronises keypad input into
// one-cycle digit strobes and sequences programming, entry, verify, open and lockout.
module combo_lock_ctrl #(
  parameter int DIGITS      = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCKOUT_CYC = 1024,
  parameter int RELOCK_CYC  = 4096,
  parameter int CHK_WAIT    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_in,
  input  logic       prog_en,
  input  logic       chk_unlock,
  output logic       key_stb,
  output logic [3:0] key_code,
  output logic       chk_prog,
  output logic       chk_clear,
  output logic       unlock,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  localparam int TMAX = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int TW   = $clog2(TMAX);
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] DIG_LAST     = DW'(DIGITS - 1);
  localparam logic [TW-1:0] VERIFY_LAST  = TW'(CHK_WAIT - 1);
  localparam logic [TW-1:0] RELOCK_LAST  = TW'(RELOCK_CYC - 1);
  localparam logic [TW-1:0] LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
  localparam logic [1:0]    FAIL_MAX     = 2'(MAX_FAILS);

  typedef enum logic [2:0] {
    S_PROG, S_IDLE, S_ENTRY, S_VERIFY, S_OPEN, S_LOCKOUT
  } state_t;

  state_t          state, state_n;
  logic [3:0]      sync1, ks;
  logic            armed, press, accept;
  logic [DW-1:0]   dcnt, dcnt_n;
  logic [TW-1:0]   tmr, tmr_n;
  logic [1:0]      fail_n, fail_inc;
  logic            clear_n;

  assign press    = armed && (ks != 4'd0);
  assign accept   = (state == S_PROG) || (state == S_IDLE) || (state == S_ENTRY);
  assign fail_inc = (fail_cnt >= FAIL_MAX) ? FAIL_MAX : fail_cnt + 2'd1;

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
    if (reset) begin
      sync1    <= '0;
      ks       <= '0;
      armed    <= 1'b1;
      key_stb  <= 1'b0;
      key_code <= '0;
    end else begin
      sync1   <= key_in;
      ks      <= sync1;
      // a press drops armed; only a released keypad re-arms, so held or changed keys stay silent
      armed   <= (ks == 4'd0);
      key_stb <= press && accept;
      if (press && accept) key_code <= ks;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_n = state;
    dcnt_n  = dcnt;
    tmr_n   = tmr;
    fail_n  = fail_cnt;
    clear_n = 1'b0;
    unique case (state)
      S_PROG: begin
        if (key_stb) begin
          if (dcnt == DIG_LAST) begin
            state_n = S_IDLE;
            dcnt_n  = '0;
          end else begin
            dcnt_n = dcnt + DW'(1);
          end
        end
      end
      // IDLE holds a zero count, so its first strobe lands in ENTRY with count 1
      S_IDLE, S_ENTRY: begin
        if (key_stb) begin
          if (dcnt == DIG_LAST) begin
            state_n = S_VERIFY;
            dcnt_n  = '0;
            tmr_n   = TW'(1);
          end else begin
            state_n = S_ENTRY;
            dcnt_n  = dcnt + DW'(1);
          end
        end
      end
      S_VERIFY: begin
        if (tmr >= VERIFY_LAST) begin
          tmr_n = '0;
          if (chk_unlock) begin
            state_n = S_OPEN;
            fail_n  = 2'd0;
          end else begin
            clear_n = 1'b1;
            fail_n  = fail_inc;
            state_n = (fail_inc == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
          end
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_OPEN: begin
        if (prog_en) begin
          state_n = S_PROG;
          clear_n = 1'b1;
          tmr_n   = '0;
        end else if (tmr == RELOCK_LAST) begin
          state_n = S_IDLE;
          clear_n = 1'b1;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_LOCKOUT: begin
        if (tmr == LOCKOUT_LAST) begin
          state_n = S_IDLE;
          fail_n  = 2'd0;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: begin
        state_n = S_PROG;
        dcnt_n  = '0;
        tmr_n   = '0;
      end
    endcase
  end

  // status outputs are registered from the next state so they track the state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_PROG;
      dcnt       <= '0;
      tmr        <= '0;
      fail_cnt   <= 2'd0;
      chk_prog   <= 1'b1;
      chk_clear  <= 1'b1;
      unlock     <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      dcnt       <= dcnt_n;
      tmr        <= tmr_n;
      fail_cnt   <= fail_n;
      chk_prog   <= (state_n == S_PROG);
      chk_clear  <= clear_n;
      unlock     <= (state_n == S_OPEN);
      locked_out <= (state_n == S_LOCKOUT);
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: key-path vector table, directed session sequences and a
// randomized attempt loop checked against an attempt-level model plus a checker model.
module tb_combo_lock_ctrl;

  localparam int DIGITS      = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int RELOCK_CYC  = 32;
  localparam int CHK_WAIT    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_in = 4'd0;
  logic       prog_en = 1'b0;
  logic       chk_unlock = 1'b0;
  logic       key_stb, chk_prog, chk_clear, unlock, locked_out;
  logic [3:0] key_code;
  logic [1:0] fail_cnt;

  combo_lock_ctrl #(
    .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS), .LOCKOUT_CYC(LOCKOUT_CYC),
    .RELOCK_CYC(RELOCK_CYC), .CHK_WAIT(CHK_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .prog_en(prog_en),
    .chk_unlock(chk_unlock), .key_stb(key_stb), .key_code(key_code),
    .chk_prog(chk_prog), .chk_clear(chk_clear), .unlock(unlock),
    .locked_out(locked_out), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] code;
    logic       prog;
  } stb_t;

  typedef struct {
    logic [3:0] key_a;
    logic [3:0] key_b;
    int         hold;
    int         gap;
    int         exp_n;
    logic [3:0] exp_code;
    logic       exp_prog;
  } vec_t;

  stb_t       stb_q[$];
  int         clr_q[$];
  logic [3:0] stored[DIGITS];
  logic [3:0] entered[DIGITS];
  int         prog_n = 0;
  int         ent_n = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // Strobe/clear logger and behavioural model of the combination checker
  initial begin
    stb_t e;
    bit   match;
    forever begin
      @(negedge clk);
      if (chk_clear === 1'b1) begin
        clr_q.push_back(cyc);
        ent_n = 0;
        if (chk_prog === 1'b1) prog_n = 0;
      end
      if (key_stb === 1'b1) begin
        e.cyc = cyc; e.code = key_code; e.prog = chk_prog;
        stb_q.push_back(e);
        if (chk_prog === 1'b1) begin
          if (prog_n < DIGITS) begin stored[prog_n] = key_code; prog_n++; end
        end else if (ent_n < DIGITS) begin
          entered[ent_n] = key_code; ent_n++;
        end
      end
      match = (ent_n == DIGITS) && (prog_n == DIGITS);
      for (int i = 0; i < DIGITS; i++)
        if (entered[i] != stored[i]) match = 1'b0;
      chk_unlock = match;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return unlock;
      1:       return locked_out;
      default: return chk_prog;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
    int n = 0;
    while (sig(sel) !== val && n < budget) begin
      tick();
      n++;
    end
    check(name, sig(sel), val);
  endtask

  task automatic press(input logic [3:0] d, input int hold, input int gap);
    key_in = d;
    repeat (hold) tick();
    key_in = 4'd0;
    repeat (gap) tick();
  endtask

  task automatic send_code(input logic [15:0] code, input bit rnd);
    for (int i = 0; i < DIGITS; i++) begin
      if (rnd) press(code[4*i +: 4], $urandom_range(1, 3), $urandom_range(1, 3));
      else     press(code[4*i +: 4], 2, 2);
    end
  endtask

  function automatic logic [15:0] rand_code();
    logic [15:0] c;
    for (int i = 0; i < DIGITS; i++) c[4*i +: 4] = 4'($urandom_range(1, 15));
    return c;
  endfunction

  task automatic do_reset();
    reset = 1'b1; key_in = 4'd0; prog_en = 1'b0;
    tick();
    check("rst_key_stb", key_stb, 0);
    check("rst_key_code", key_code, 0);
    check("rst_chk_prog", chk_prog, 1);
    check("rst_chk_clear", chk_clear, 1);
    check("rst_unlock", unlock, 0);
    check("rst_locked_out", locked_out, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    reset = 1'b0;
    tick();
    check("rst_release_clear", chk_clear, 0);
    check("rst_release_prog", chk_prog, 1);
  endtask

  initial begin
    vec_t        vecs[6];
    int          n0, c0, nclr, s, r, l, mfail;
    logic [15:0] mcode, attempt;
    logic        right;

    // key_a, key_b (changed-to without release), hold, gap, strobes, code, chk_prog at strobe
    vecs[0] = '{4'd3,  4'd0, 10, 3, 1, 4'd3,  1'b1};
    vecs[1] = '{4'd3,  4'd5, 10, 3, 1, 4'd3,  1'b1};
    vecs[2] = '{4'd9,  4'd0, 1,  2, 1, 4'd9,  1'b1};
    vecs[3] = '{4'd15, 4'd0, 4,  1, 1, 4'd15, 1'b1};
    vecs[4] = '{4'd1,  4'd0, 3,  2, 1, 4'd1,  1'b0};
    vecs[5] = '{4'd0,  4'd0, 4,  2, 0, 4'd0,  1'b0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      n0 = stb_q.size();
      c0 = cyc;
      key_in = vecs[i].key_a;
      repeat (vecs[i].hold) tick();
      if (vecs[i].key_b != 4'd0) begin
        key_in = vecs[i].key_b;
        repeat (vecs[i].hold) tick();
      end
      key_in = 4'd0;
      repeat (vecs[i].gap + 3) tick();
      check($sformatf("vec%0d_strobes", i), stb_q.size() - n0, vecs[i].exp_n);
      if (vecs[i].exp_n > 0) begin
        check($sformatf("vec%0d_code", i), stb_q[n0].code, vecs[i].exp_code);
        check($sformatf("vec%0d_latency", i), stb_q[n0].cyc - c0, 3);
        check($sformatf("vec%0d_prog", i), stb_q[n0].prog, vecs[i].exp_prog);
      end
    end
    check("vec_end_unlock", unlock, 0);

    // Program 1,2,3,4 then open with it
    do_reset();
    send_code(16'h4321, 0);
    repeat (2) tick();
    check("progA_idle", chk_prog, 0);
    send_code(16'h4321, 0);
    s = stb_q[$].cyc;
    wait_sig("openA_rise", 0, 1'b1, 20);
    r = cyc;
    check("openA_latency", r - s, CHK_WAIT);
    nclr = clr_q.size();
    wait_sig("openA_fall", 0, 1'b0, RELOCK_CYC + 10);
    check("openA_len", cyc - r, RELOCK_CYC);
    check("openA_clr_count", clr_q.size() - nclr, 1);
    check("openA_clr_at_fall", clr_q[$], cyc);
    check("openA_idle_prog", chk_prog, 0);

    // Three wrong entries lead to lockout
    for (int i = 1; i <= MAX_FAILS; i++) begin
      nclr = clr_q.size();
      send_code(16'h1111, 0);
      repeat (4) tick();
      check($sformatf("lock_fail%0d", i), fail_cnt, i);
      check($sformatf("lock_clr%0d", i), clr_q.size() - nclr, 1);
    end
    l = clr_q[$];
    check("lock_active", locked_out, 1);
    n0 = stb_q.size();
    press(4'd7, 2, 2);
    press(4'd8, 2, 2);
    check("lock_no_strobe", stb_q.size() - n0, 0);
    wait_sig("lock_end", 1, 1'b0, LOCKOUT_CYC + 10);
    check("lock_len", cyc - l, LOCKOUT_CYC);
    check("lock_fail_clear", fail_cnt, 0);
    check("lock_idle_prog", chk_prog, 0);

    // Wrong, wrong, right: count clears on open and does not carry over
    send_code(16'h2222, 0); repeat (4) tick();
    send_code(16'h3333, 0); repeat (4) tick();
    check("wwr_fail2", fail_cnt, 2);
    send_code(16'h4321, 0);
    wait_sig("wwr_open", 0, 1'b1, 20);
    check("wwr_fail_zero", fail_cnt, 0);
    wait_sig("wwr_relock", 0, 1'b0, RELOCK_CYC + 10);
    send_code(16'h5555, 0); repeat (4) tick();
    check("wwr_fail_fresh", fail_cnt, 1);

    // prog_en in the expiry cycle wins over relock
    send_code(16'h4321, 0);
    wait_sig("pe_open", 0, 1'b1, 20);
    r = cyc;
    n0 = 0;
    while (cyc != r + RELOCK_CYC - 1 && n0 < RELOCK_CYC) begin tick(); n0++; end
    prog_en = 1'b1;
    tick();
    prog_en = 1'b0;
    check("pe_prog", chk_prog, 1);
    check("pe_unlock", unlock, 0);
    check("pe_clear", chk_clear, 1);
    send_code(16'h5678, 0);
    repeat (2) tick();
    check("pe_reprog_idle", chk_prog, 0);
    prog_en = 1'b1;
    repeat (3) tick();
    prog_en = 1'b0;
    check("pe_idle_ignored", chk_prog, 0);
    send_code(16'h5678, 0);
    wait_sig("pe_new_code_open", 0, 1'b1, 20);

    // Reset in the middle of an entry
    wait_sig("rm_relock", 0, 1'b0, RELOCK_CYC + 10);
    press(4'd2, 2, 2);
    press(4'd4, 2, 2);
    do_reset();
    send_code(16'h8642, 0);
    repeat (2) tick();
    check("rm_prog_done", chk_prog, 0);
    send_code(16'h8642, 0);
    wait_sig("rm_open", 0, 1'b1, 20);

    // Randomized attempts against an attempt-level model
    do_reset();
    mcode = rand_code();
    send_code(mcode, 1);
    repeat (2) tick();
    check("rnd_prog_done", chk_prog, 0);
    mfail = 0;
    for (int it = 0; it < 40; it++) begin
      attempt = ($urandom_range(0, 2) == 0) ? mcode : rand_code();
      right = (attempt == mcode);
      send_code(attempt, 1);
      repeat (4) tick();
      if (right) mfail = 0;
      else       mfail++;
      check($sformatf("rnd%0d_unlock", it), unlock, right);
      check($sformatf("rnd%0d_locked", it), locked_out, mfail == MAX_FAILS);
      check($sformatf("rnd%0d_fail", it), fail_cnt, mfail);
      if (right) begin
        n0 = stb_q.size();
        press(4'd7, 2, 2);
        check($sformatf("rnd%0d_open_drop", it), stb_q.size() - n0, 0);
        if ($urandom_range(0, 3) == 0) begin
          prog_en = 1'b1;
          tick();
          prog_en = 1'b0;
          check($sformatf("rnd%0d_pe_prog", it), chk_prog, 1);
          check($sformatf("rnd%0d_pe_unlock", it), unlock, 0);
          mcode = rand_code();
          send_code(mcode, 1);
          repeat (2) tick();
          check($sformatf("rnd%0d_reprog", it), chk_prog, 0);
        end else begin
          wait_sig($sformatf("rnd%0d_relock", it), 0, 1'b0, RELOCK_CYC + 8);
        end
      end else if (mfail == MAX_FAILS) begin
        wait_sig($sformatf("rnd%0d_lock_end", it), 1, 1'b0, LOCKOUT_CYC + 8);
        mfail = 0;
        check($sformatf("rnd%0d_lock_fail0", it), fail_cnt, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
